ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 20 ++
 rtl/ram_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester single-port RAM arbiter:
// default widths, FSM state encoding and a grant-index helper.
package ram_arb_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RDWAIT = 2'd2
   } state_e;

   // Index of a one-hot 2-bit grant (bit 1 set -> requester 1).
   function automatic logic grant_index(input logic [1:0] onehot);
      return onehot[1];
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone valid requester wins, on contention
// the requester that was not granted last wins.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // One-hot grant selection
   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two command streams onto one synchronous single-port RAM;
// one access per command, read data returned to its owner two cycles later.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [1:0]          req_we,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic [1:0]          rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                ram_cs,
   output logic                ram_wr,
   output logic                ram_rd,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_wdata,
   input  logic [DATA_W-1:0]   ram_rdata
);

   state_e              state;
   state_e              state_nxt;
   logic                last_grant;
   logic                grant_idx;
   logic [1:0]          grant;
   logic                hs;
   logic                sel;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   rr_arb2 u_rr_arb2 (
      .valid      (req_valid),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // Ready is gated by reset so no command can transfer while rst_n is low
   always_comb begin
      if (state == ST_IDLE && rst_n) begin
         req_ready = grant;
      end else begin
         req_ready = 2'b00;
      end
   end

   // Handshake detection and selection of the winning command fields
   always_comb begin
      hs        = |(req_valid & req_ready);
      sel       = grant_index(req_ready);
      sel_we    = sel ? req_we[1] : req_we[0];
      sel_addr  = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      sel_wdata = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
   end

   // Next-state logic; ram_wr is high in ACCESS exactly for writes
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   state_nxt = hs ? ST_ACCESS : ST_IDLE;
         ST_ACCESS: state_nxt = ram_wr ? ST_IDLE : ST_RDWAIT;
         ST_RDWAIT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // State and arbitration history
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         grant_idx  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (hs) begin
            last_grant <= sel;
            grant_idx  <= sel;
         end
      end
   end

   // RAM strobes are the registered handshake, so they are high only in ACCESS
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ram_cs    <= 1'b0;
         ram_wr    <= 1'b0;
         ram_rd    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         ram_cs <= hs;
         ram_wr <= hs & sel_we;
         ram_rd <= hs & ~sel_we;
         if (hs) begin
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
         end
      end
   end

   // Read response: capture RAM data in RDWAIT, strobe the owner next cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 2'b00;
         rsp_rdata <= '0;
      end else begin
         if (state == ST_RDWAIT) begin
            rsp_valid <= {grant_idx, ~grant_idx};
            rsp_rdata <= ram_rdata;
         end else begin
            rsp_valid <= 2'b00;
         end
      end
   end

endmodule
